// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver state encodings and
// the oversample divisor calculation.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  function automatic int calc_dvsr(input int clk_freq, input int baud);
    return clk_freq / (OVERSAMPLE * baud);
  endfunction

endpackage

// File: rtl/uart_rx_buffer_baud_tick_gen.sv
// Free-running divider producing a one-cycle tick at 16x the line rate.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 19_200
) (
  input  logic i_clock,
  input  logic i_reset,
  output logic o_tick
);

  localparam int DVSR  = calc_dvsr(CLK_FREQ, BAUD);
  localparam int CNT_W = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DVSR - 1);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset)               r_cnt <= '0;
    else if (r_cnt == CNT_LAST) r_cnt <= '0;
    else                        r_cnt <= r_cnt + 1'b1;
  end

  assign o_tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_buffer.sv
// 16x-oversampled 8N1 receiver with a first-word-fall-through byte FIFO.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 19_200,
  parameter int FIFO_W   = 4
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_rx,
  input  logic            i_rd,
  output logic [DBIT-1:0] o_data,
  output logic            o_fifo_empty,
  output logic            o_fifo_full,
  output logic            o_frame_err,
  output logic            o_overrun
);

  localparam int DEPTH = 2 ** FIFO_W;
  localparam int S_W   = $clog2((SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE);
  localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [S_W-1:0]    S_HALF      = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0]    S_BIT_LAST  = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0]    S_STOP_LAST = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0]    N_LAST      = N_W'(DBIT - 1);
  localparam logic [FIFO_W:0]   FULL_COUNT  = (FIFO_W + 1)'(DEPTH);

  logic            w_tick;
  logic [1:0]      r_sync;
  logic            w_rx_s;
  rx_state_e       r_state, w_state_nxt;
  logic [S_W-1:0]  r_s, w_s_nxt;
  logic [N_W-1:0]  r_n, w_n_nxt;
  logic [DBIT-1:0] r_shreg, w_shreg_nxt;
  logic            w_push, w_frame_err;

  baud_tick_gen #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_tick (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .o_tick  (w_tick)
  );

  // Preset high so reset release never looks like a start edge.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_sync <= 2'b11;
    else          r_sync <= {r_sync[0], i_rx};
  end
  assign w_rx_s = r_sync[1];

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= RX_IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_shreg <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_n     <= w_n_nxt;
      r_shreg <= w_shreg_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_n_nxt     = r_n;
    w_shreg_nxt = r_shreg;
    w_push      = 1'b0;
    w_frame_err = 1'b0;
    unique case (r_state)
      RX_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = RX_START;
          w_s_nxt     = '0;
        end
      end
      RX_START: begin
        if (w_tick) begin
          if (r_s == S_HALF) begin
            w_s_nxt = '0;
            w_n_nxt = '0;
            w_state_nxt = w_rx_s ? RX_IDLE : RX_DATA;
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (w_tick) begin
          if (r_s == S_BIT_LAST) begin
            w_shreg_nxt = {w_rx_s, r_shreg[DBIT-1:1]};
            w_s_nxt     = '0;
            if (r_n == N_LAST) w_state_nxt = RX_STOP;
            else               w_n_nxt     = r_n + 1'b1;
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (w_tick) begin
          if (r_s == S_STOP_LAST) begin
            w_state_nxt = RX_IDLE;
            w_push      = w_rx_s;
            w_frame_err = ~w_rx_s;
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  logic [DBIT-1:0]   r_mem [DEPTH];
  logic [FIFO_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_W:0]   r_count, w_count_nxt;
  logic              r_empty, r_full, r_frame_err, r_overrun;
  logic              w_pop, w_wr_en;

  // A full FIFO still accepts a byte when the same cycle pops one.
  assign w_pop   = i_rd & ~r_empty;
  assign w_wr_en = w_push & (~r_full | w_pop);

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_en && !w_pop)      w_count_nxt = r_count + 1'b1;
    else if (!w_wr_en && w_pop) w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count     <= w_count_nxt;
      r_empty     <= (w_count_nxt == '0);
      r_full      <= (w_count_nxt == FULL_COUNT);
      r_frame_err <= w_frame_err;
      r_overrun   <= w_push & r_full & ~w_pop;
    end
  end

  // NOTE: the storage array has no reset; o_data is gated while empty so stale contents never show.
  always_ff @(posedge i_clock) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= r_shreg;
  end

  assign o_data       = r_empty ? '0 : r_mem[r_rd_ptr];
  assign o_fifo_empty = r_empty;
  assign o_fifo_full  = r_full;
  assign o_frame_err  = r_frame_err;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Scoreboard bench for uart_rx_buffer: frames are driven serially, expected bytes
// queued at send time, and a monitor checks every pop against the queue.
module tb_uart_rx_buffer;

  localparam int DBIT     = 8;
  localparam int SB_TICK  = 16;
  localparam int BAUD     = 19_200;
  localparam int DVSR     = 4;
  localparam int CLK_FREQ = 16 * BAUD * DVSR;
  localparam int FIFO_W   = 4;
  localparam int BIT      = 16 * DVSR;
  // Edges from a tick-aligned start bit to the edge that pushes the byte:
  // 3 cycles to enter START, then the stop-bit final tick is tick number 8+128+16.
  localparam int PUSH_CYC = 3 + DVSR * (8 + 16 * DBIT + SB_TICK - 1);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_rx = 1'b1;
  logic       i_rd = 1'b0;
  logic [7:0] o_data;
  logic       o_fifo_empty, o_fifo_full, o_frame_err, o_overrun;

  uart_rx_buffer #(
    .DBIT     (DBIT),
    .SB_TICK  (SB_TICK),
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .FIFO_W   (FIFO_W)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_rx         (i_rx),
    .i_rd         (i_rd),
    .o_data       (o_data),
    .o_fifo_empty (o_fifo_empty),
    .o_fifo_full  (o_fifo_full),
    .o_frame_err  (o_frame_err),
    .o_overrun    (o_overrun)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  int         n_ferr = 0;
  int         n_ovr = 0;
  int         tb_cyc;
  logic [7:0] exp_q[$];

  // Edges since reset release; the tick phase is tb_cyc mod DVSR.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= 0;
    else        tb_cyc <= tb_cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (i_rd && !o_fifo_empty) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pop: got 0x%0h, no byte expected", o_data);
        end else begin
          check("pop_data", o_data, exp_q.pop_front());
        end
      end
      if (o_frame_err) n_ferr++;
      if (o_overrun)   n_ovr++;
    end
  end

  task automatic sync_edge();
    @(posedge clk);
    #1;
  endtask

  // stop_low > 0 holds the stop bit low for that many cycles, then idles.
  task automatic send_frame(input logic [7:0] b, input int stop_low);
    i_rx = 1'b0;
    repeat (BIT) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      repeat (BIT) @(posedge clk);
      #1;
    end
    if (stop_low > 0) begin
      i_rx = 1'b0;
      repeat (stop_low) @(posedge clk);
      #1;
      i_rx = 1'b1;
      repeat (BIT - stop_low) @(posedge clk);
      #1;
    end else begin
      i_rx = 1'b1;
      repeat (BIT) @(posedge clk);
      #1;
    end
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic send_store(input logic [7:0] b);
    exp_q.push_back(b);
    send_frame(b, 0);
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      sync_edge();
      i_rd = 1'b1;
      sync_edge();
      i_rd = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_empty", o_fifo_empty, 1);
    check("reset_data", o_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_full", o_fifo_full, 0);
    check("reset_pulses", {o_frame_err, o_overrun}, 0);
    repeat (10 * BIT) @(posedge clk);
    @(negedge clk);
    check("idle_empty", o_fifo_empty, 1);
    check("idle_no_pulses", n_ferr + n_ovr, 0);

    // 0xA5: head visible between 9 and 10 bit times after the start edge.
    sync_edge();
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 0);
      begin
        repeat (9 * BIT) @(posedge clk);
        @(negedge clk);
        check("a5_not_early", o_fifo_empty, 1);
        repeat (BIT) @(posedge clk);
        @(negedge clk);
        check("a5_arrived", o_fifo_empty, 0);
        check("a5_head", o_data, 8'hA5);
      end
    join
    pop_n(1);
    @(negedge clk);
    check("a5_drained_empty", o_fifo_empty, 1);
    check("a5_drained_data", o_data, 0);

    // Short low glitch on the idle line is rejected in START.
    sync_edge();
    i_rx = 1'b0;
    repeat (3 * DVSR) @(posedge clk);
    #1;
    i_rx = 1'b1;
    repeat (4 * BIT) @(posedge clk);
    @(negedge clk);
    check("glitch_empty", o_fifo_empty, 1);
    check("glitch_no_ferr", n_ferr, 0);

    // 0x3C with a low stop bit: one framing error, nothing stored.
    sync_edge();
    send_frame(8'h3C, 40);
    @(negedge clk);
    check("ferr_count", n_ferr, 1);
    check("ferr_empty", o_fifo_empty, 1);

    // Fill to 16, 17th byte overruns and is dropped.
    for (int i = 0; i < 16; i++) begin
      send_store(8'(i));
      if (i == 14) begin
        @(negedge clk);
        check("fill15_not_full", o_fifo_full, 0);
      end
    end
    @(negedge clk);
    check("fill16_full", o_fifo_full, 1);
    check("fill16_no_ovr", n_ovr, 0);
    send_frame(8'h10, 0);
    @(negedge clk);
    check("ovr_count", n_ovr, 1);
    check("ovr_still_full", o_fifo_full, 1);
    check("ovr_head", o_data, 8'h00);
    pop_n(16);
    @(negedge clk);
    check("ovr_drain_empty", o_fifo_empty, 1);
    check("ovr_drain_all", exp_q.size(), 0);

    // Refill, then complete 0x10 with a pop in exactly the push cycle.
    for (int i = 0; i < 16; i++) send_store(8'(i));
    @(negedge clk);
    check("refill_full", o_fifo_full, 1);
    sync_edge();
    while (tb_cyc % DVSR != 0) sync_edge();
    exp_q.push_back(8'h10);
    fork
      send_frame(8'h10, 0);
      begin
        repeat (PUSH_CYC) @(posedge clk);
        #1;
        i_rd = 1'b1;
        @(posedge clk);
        #1;
        i_rd = 1'b0;
      end
    join
    @(negedge clk);
    check("simul_no_ovr", n_ovr, 1);
    check("simul_full", o_fifo_full, 1);
    check("simul_head", o_data, 8'h01);
    pop_n(16);
    @(negedge clk);
    check("simul_drain_empty", o_fifo_empty, 1);
    check("simul_drain_all", exp_q.size(), 0);

    // Reset in the middle of 0xFF's data bits, then 0x12.
    sync_edge();
    i_rx = 1'b0;
    repeat (BIT) @(posedge clk);
    #1;
    i_rx = 1'b1;
    repeat (3 * BIT) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (16 * BIT) @(posedge clk);
    @(negedge clk);
    check("midreset_empty", o_fifo_empty, 1);
    sync_edge();
    send_store(8'h12);
    @(negedge clk);
    check("midreset_head", o_data, 8'h12);
    pop_n(1);
    @(negedge clk);
    check("midreset_only_one", o_fifo_empty, 1);
    check("midreset_q", exp_q.size(), 0);
    check("final_ferr", n_ferr, 1);
    check("final_ovr", n_ovr, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
